// File: rtl/ddr2_bridge_pkg.sv
// Shared types and helpers for the host-FIFO <-> MCB port-0 burst bridge.
package ddr2_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_FILL  = 3'd1,
    WR_CMD   = 3'd2,
    RD_CMD   = 3'd3,
    RD_DRAIN = 3'd4
  } state_e;

  localparam logic [2:0] MCB_WR = 3'b000;
  localparam logic [2:0] MCB_RD = 3'b001;

  // Byte address of a burst: index * words-per-burst * 4 bytes per word.
  function automatic logic [63:0] burst_byte_addr(input logic [31:0] ptr,
                                                  input logic [31:0] burst_len);
    return {32'd0, ptr} * {32'd0, burst_len} * 64'd4;
  endfunction

endpackage

// File: rtl/burst_word_counter.sv
// Modulo-BURST_LEN word counter; wraps to zero after the last word of a burst.
module burst_word_counter #(
  parameter int BURST_LEN = 16
) (
  input  logic c3_clk0,
  input  logic c3_rst_n,
  input  logic inc,
  output logic last
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CW'(BURST_LEN - 1));

  // Next count: advance per word, wrap on the terminal word.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge c3_clk0 or negedge c3_rst_n) begin
    if (!c3_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr2_burst_bridge.sv
// Burst bridge between the host pipe FIFOs and MCB user port 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | apply pending pointer reload, else arbitrate (write first)
// WR_FILL  | move BURST_LEN words pipe-in FIFO -> MCB write FIFO
// WR_CMD   | issue burst write command at wr_ptr
// RD_CMD   | issue burst read command at rd_ptr
// RD_DRAIN | move BURST_LEN words MCB read FIFO -> pipe-out FIFO
module ddr2_burst_bridge
  import ddr2_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 30,
  parameter int IDX_W     = 16
) (
  input  logic              c3_clk0,
  input  logic              c3_rst_n,
  input  logic              calib_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              addr_rst,
  input  logic [IDX_W-1:0]  wr_start_idx,
  input  logic [IDX_W-1:0]  wr_stop_idx,
  input  logic [IDX_W-1:0]  rd_start_idx,
  input  logic [IDX_W-1:0]  rd_stop_idx,
  input  logic [DATA_W-1:0] ib_data,
  input  logic [9:0]        ib_count,
  output logic              ib_rd_en,
  input  logic [9:0]        ob_free,
  output logic              ob_wr_en,
  output logic [DATA_W-1:0] ob_data,
  output logic              p0_cmd_en,
  output logic [2:0]        p0_cmd_instr,
  output logic [5:0]        p0_cmd_bl,
  output logic [ADDR_W-1:0] p0_cmd_byte_addr,
  input  logic              p0_cmd_full,
  output logic              p0_wr_en,
  output logic [DATA_W-1:0] p0_wr_data,
  output logic [3:0]        p0_wr_mask,
  input  logic              p0_wr_full,
  output logic              p0_rd_en,
  input  logic [DATA_W-1:0] p0_rd_data,
  input  logic              p0_rd_empty,
  output logic              wr_done,
  output logic              rd_done,
  output logic [2:0]        state_dbg
);

  localparam logic [5:0] BL_M1 = 6'(BURST_LEN - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               wr_fin_q, wr_fin_d;
  logic               rd_fin_q, rd_fin_d;
  logic               rd_done_q, rd_done_d;
  logic               wr_done_q, wr_done_d;
  logic               rst_pend_q, rst_pend_d;

  logic               cnt_inc;
  logic               cnt_last;
  logic               wr_go, rd_go;
  logic               wr_last, rd_last;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;

  burst_word_counter #(.BURST_LEN(BURST_LEN)) u_word_cnt (
    .c3_clk0  (c3_clk0),
    .c3_rst_n (c3_rst_n),
    .inc      (cnt_inc),
    .last     (cnt_last)
  );

  assign wr_go   = calib_done & wr_req & ~wr_fin_q & (ib_count >= 10'(BURST_LEN));
  assign rd_go   = calib_done & rd_req & ~rd_fin_q & (ob_free >= 10'(BURST_LEN));
  // An inverted window collapses to the single burst at its start index.
  assign wr_last = (wr_ptr_q == wr_stop_idx) || (wr_stop_idx < wr_start_idx);
  assign rd_last = (rd_ptr_q == rd_stop_idx) || (rd_stop_idx < rd_start_idx);
  assign wr_addr = ADDR_W'(burst_byte_addr(32'(wr_ptr_q), 32'(BURST_LEN)));
  assign rd_addr = ADDR_W'(burst_byte_addr(32'(rd_ptr_q), 32'(BURST_LEN)));

  assign p0_wr_mask = 4'b0000;
  assign wr_done    = wr_done_q;
  assign rd_done    = rd_done_q;
  assign state_dbg  = state_q;

  // Next-state and datapath strobes; everything idles at zero outside its state.
  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    wr_fin_d         = wr_fin_q;
    rd_fin_d         = rd_fin_q;
    rd_done_d        = rd_done_q;
    wr_done_d        = 1'b0;
    rst_pend_d       = rst_pend_q | addr_rst;
    cnt_inc          = 1'b0;
    ib_rd_en         = 1'b0;
    p0_wr_en         = 1'b0;
    p0_wr_data       = '0;
    p0_rd_en         = 1'b0;
    ob_wr_en         = 1'b0;
    ob_data          = '0;
    p0_cmd_en        = 1'b0;
    p0_cmd_instr     = MCB_WR;
    p0_cmd_bl        = '0;
    p0_cmd_byte_addr = '0;
    case (state_q)
      IDLE: begin
        // A reload (fresh or latched mid-burst) wins over any request this cycle.
        if (addr_rst || rst_pend_q) begin
          wr_ptr_d   = wr_start_idx;
          rd_ptr_d   = rd_start_idx;
          wr_fin_d   = 1'b0;
          rd_fin_d   = 1'b0;
          rd_done_d  = 1'b0;
          rst_pend_d = 1'b0;
        end else if (wr_go) begin
          state_d = WR_FILL;
        end else if (rd_go) begin
          state_d = RD_CMD;
        end
      end
      WR_FILL: begin
        p0_wr_en   = ~p0_wr_full;
        ib_rd_en   = ~p0_wr_full;
        p0_wr_data = ib_data;
        cnt_inc    = ~p0_wr_full;
        if (cnt_inc && cnt_last) begin
          state_d = WR_CMD;
        end
      end
      WR_CMD: begin
        p0_cmd_instr     = MCB_WR;
        p0_cmd_bl        = BL_M1;
        p0_cmd_byte_addr = wr_addr;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          state_d   = IDLE;
          if (wr_last) begin
            wr_fin_d  = 1'b1;
            wr_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
          end
        end
      end
      RD_CMD: begin
        p0_cmd_instr     = MCB_RD;
        p0_cmd_bl        = BL_M1;
        p0_cmd_byte_addr = rd_addr;
        if (!p0_cmd_full) begin
          p0_cmd_en = 1'b1;
          state_d   = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        p0_rd_en = ~p0_rd_empty;
        ob_wr_en = ~p0_rd_empty;
        ob_data  = p0_rd_data;
        cnt_inc  = ~p0_rd_empty;
        if (cnt_inc && cnt_last) begin
          state_d = IDLE;
          if (rd_last) begin
            rd_fin_d  = 1'b1;
            rd_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and flag registers.
  always_ff @(posedge c3_clk0 or negedge c3_rst_n) begin
    if (!c3_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_fin_q   <= 1'b0;
      rd_fin_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_fin_q   <= wr_fin_d;
      rd_fin_q   <= rd_fin_d;
      rd_done_q  <= rd_done_d;
      wr_done_q  <= wr_done_d;
      rst_pend_q <= rst_pend_d;
    end
  end

endmodule

// File: doc/ddr2_burst_bridge.md
Name: ddr2_burst_bridge

Overview:
- Moves data between the host-side FIFOs and MIG/MCB user port 0. The host-side FIFOs are the pipe-in FIFO behind ep 0x80 and the pipe-out FIFO behind ep 0xA0.
- Write path: host pipe-in FIFO -> MCB write FIFO -> burst write command.
- Read path: burst read command -> MCB read FIFO -> host pipe-out FIFO.
- Sits between the host endpoint logic and the memory controller. Burst windows come from wire-ins 0x01-0x04. Request levels come from wire-in 0x00 bits 3 (write) and 2 (read).

Parameters:
- DATA_W, 32, FIFO/MCB data width.
- BURST_LEN, 16, words per burst; range 1-64.
- ADDR_W, 30, MCB byte address width.
- IDX_W, 16, burst-index width of the window registers.

Ports:
- c3_clk0  in  1  MCB user clock; sole clock.
- c3_rst_n  in  1  asynchronous active-low reset.
- calib_done  in  1  MCB calibration complete.
- wr_req  in  1  write request level.
- rd_req  in  1  read request level.
- addr_rst  in  1  one-cycle pulse; reload pointers from the start indices (trigger 0x41 bit 0).
- wr_start_idx  in  IDX_W  first write burst index.
- wr_stop_idx  in  IDX_W  last write burst index, inclusive.
- rd_start_idx  in  IDX_W  first read burst index.
- rd_stop_idx  in  IDX_W  last read burst index, inclusive.
- ib_data  in  DATA_W  pipe-in FIFO head word (FWFT).
- ib_count  in  10  pipe-in FIFO word count.
- ib_rd_en  out  1  pop pipe-in FIFO.
- ob_free  in  10  pipe-out FIFO free words.
- ob_wr_en  out  1  push to pipe-out FIFO.
- ob_data  out  DATA_W  word to pipe-out FIFO.
- p0_cmd_en  out  1  MCB command strobe.
- p0_cmd_instr  out  3  000 write, 001 read.
- p0_cmd_bl  out  6  burst length minus one.
- p0_cmd_byte_addr  out  ADDR_W  byte address.
- p0_cmd_full  in  1  MCB command FIFO full.
- p0_wr_en  out  1  MCB write-data strobe.
- p0_wr_data  out  DATA_W  MCB write data.
- p0_wr_mask  out  4  always 4'b0000.
- p0_wr_full  in  1  MCB write FIFO full.
- p0_rd_en  out  1  MCB read-data strobe.
- p0_rd_data  in  DATA_W  MCB read data.
- p0_rd_empty  in  1  MCB read FIFO empty.
- wr_done  out  1  one-cycle pulse at end of the write window (trigger 0x60 bit 0).
- rd_done  out  1  sticky flag: read window complete.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset: all outputs and internal registers zero; state IDLE; pointers 0. Asynchronous assertion, deassertion synchronous to c3_clk0.
- States: IDLE=0, WR_FILL=1, WR_CMD=2, RD_CMD=3, RD_DRAIN=4.
- Address: byte_addr = ptr * BURST_LEN * 4, truncated to ADDR_W.
- Window-exhausted flags: wr_fin and rd_fin, both sticky.
- IDLE -> WR_FILL when calib_done & wr_req & !wr_fin & ib_count >= BURST_LEN. Write takes priority over read.
- IDLE -> RD_CMD when calib_done & rd_req & !rd_fin & ob_free >= BURST_LEN and the write condition is false.
- WR_FILL:
  - ib_rd_en = p0_wr_en = !p0_wr_full; p0_wr_data = ib_data, combinational from the FWFT head.
  - Word counter increments per transfer. After BURST_LEN transfers -> WR_CMD.
- WR_CMD:
  - Hold until !p0_cmd_full, then p0_cmd_en=1 for 1 cycle with instr=000, bl=BURST_LEN-1, addr from wr_ptr.
  - If wr_ptr == wr_stop_idx: set wr_fin and pulse wr_done on the cycle after the command. Otherwise wr_ptr++.
  - -> IDLE.
- RD_CMD: same command handshake with instr=001 and addr from rd_ptr; -> RD_DRAIN.
- RD_DRAIN:
  - p0_rd_en = ob_wr_en = !p0_rd_empty; ob_data = p0_rd_data.
  - After BURST_LEN words: if rd_ptr == rd_stop_idx, set rd_fin and rd_done; else rd_ptr++.
  - -> IDLE.
- Requests are sampled only in IDLE. Deasserting wr_req/rd_req mid-burst never truncates a burst.
- addr_rst:
  - In IDLE: load wr_ptr=wr_start_idx and rd_ptr=rd_start_idx; clear wr_fin, rd_fin, rd_done.
  - Outside IDLE: latched and applied on the next entry to IDLE, before any new request is accepted.
- Window with stop < start: treated as a single burst at start; the block sets the fin flag after that one burst.
- calib_done falling mid-burst: the current burst completes; no new burst starts.
- Pointer arithmetic wraps at IDX_W bits.

Decomposition:
- Package ddr2_bridge_pkg holds:
  - state enum;
  - instruction constants MCB_WR=3'b000, MCB_RD=3'b001;
  - the byte-address function.
- One sub-module, burst_word_counter: a BURST_LEN-modulo counter with a terminal flag, instanced once and shared by WR_FILL and RD_DRAIN.

Test Plan:
- Reset with ib_count=40, wr_req=1, calib_done=0 -> no p0_cmd_en. Raise calib_done -> 16 writes, then cmd at addr 0x0, bl=15.
- wr window 0..1, 32 words preloaded, addr_rst -> two write commands at byte addr 0x00 and 0x40, then exactly one wr_done pulse.
- p0_wr_full toggled every other cycle during WR_FILL -> exactly 16 p0_wr_en pulses, and data order is preserved.
- wr_req and rd_req both asserted, ib_count=16, ob_free=64 -> write burst issues before read.
- Read window 2..2, ob_free=16, MCB model returns 0x100..0x10F with random p0_rd_empty gaps -> ob_data sequence 0x100..0x10F, rd_done=1.
- Loopback: write 64 bytes, then read back through the same window -> 0 mismatches. Asserting c3_rst_n low mid-RD_DRAIN returns all outputs to 0 asynchronously.
